binary_mul_booth_seq: RTL

Parametrised iterative radix-4 Booth multiplier. It is the next generation of the team's fixed-width binary multipliers: operand width is a parameter, signed/unsigned is chosen per operation, the product is a full exact 2W bits, and a valid/ready handshake on both sides replaces the single `en` strobe. It trades the single-cycle array for W/2+1 cycles of one shared adder. It sits wherever an operand pair can tolerate multi-cycle latency, such as DSP accumulators and address scaling.

---
 rtl/binary_mul_pkg.sv | 20 ++
 rtl/booth_r4_enc.sv | 16 +
 rtl/binary_mul_booth_seq.sv | 118 +++++++++++
 3 files changed

// File: rtl/binary_mul_pkg.sv
// Shared types and helpers for the iterative radix-4 Booth multiplier.
package binary_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  typedef struct packed {
    logic neg;
    logic two;
    logic zero;
  } booth_digit_t;

  function automatic int unsigned booth_iters(input int unsigned w);
    return w / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth recoder: 3-bit multiplier window {b[i+1], b[i], b[i-1]} to a digit in {0, +-1, +-2}.
module booth_r4_enc
  import binary_mul_pkg::*;
(
  input  logic [2:0]   win,
  output booth_digit_t digit
);

  always_comb begin
    digit      = '0;
    digit.zero = (win == 3'b000) || (win == 3'b111);
    digit.two  = (win == 3'b011) || (win == 3'b100);
    digit.neg  = win[2] & ~(win[1] & win[0]);
  end

endmodule

// File: rtl/binary_mul_booth_seq.sv
// Parametrised iterative radix-4 Booth multiplier with valid/ready handshakes on both sides.
module binary_mul_booth_seq
  import binary_mul_pkg::*;
#(
  parameter int unsigned W = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           is_signed,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p
);

  localparam int unsigned N  = booth_iters(W);
  localparam int unsigned AW = 2 * W + 4;
  localparam int unsigned CW = $clog2(N);

  mul_state_e   state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] acc;
  logic [AW-1:0] mcand;
  logic [W+2:0]  mplr;
  logic          out_valid_r;

  logic          accept;
  logic          last;
  logic [W+1:0]  a_ext;
  logic [W+1:0]  b_ext;
  booth_digit_t  digit;
  logic [AW-1:0] sel;
  logic [AW-1:0] addend;
  logic [AW-1:0] sum;

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = out_valid_r;
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == '0);

  // Two extra bits make unsigned operands non-negative under signed Booth recoding.
  assign a_ext = {{2{is_signed & a[W-1]}}, a};
  assign b_ext = {{2{is_signed & b[W-1]}}, b};

  booth_r4_enc u_enc (
    .win   (mplr[2:0]),
    .digit (digit)
  );

  // Multiplicand is pre-shifted each iteration, so one full-width adder covers every digit position.
  always_comb begin
    sel    = '0;
    addend = '0;
    if (!digit.zero) begin
      sel = digit.two ? {mcand[AW-2:0], 1'b0} : mcand;
    end
    addend = digit.neg ? ~sel : sel;
    sum    = acc + addend + AW'(digit.neg);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      out_valid_r <= 1'b0;
      p           <= '0;
      cnt         <= '0;
      acc         <= '0;
      mcand       <= '0;
      mplr        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= RUN;
            acc   <= '0;
            mcand <= {{(W + 2){a_ext[W+1]}}, a_ext};
            mplr  <= {b_ext, 1'b0};
            cnt   <= CW'(N - 1);
          end
        end
        RUN: begin
          acc   <= sum;
          mcand <= mcand << 2;
          mplr  <= {{2{mplr[W+2]}}, mplr[W+2:2]};
          if (last) begin
            state       <= DONE;
            out_valid_r <= 1'b1;
            p           <= sum[2*W-1:0];
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            if (in_valid) begin
              state <= RUN;
              acc   <= '0;
              mcand <= {{(W + 2){a_ext[W+1]}}, a_ext};
              mplr  <= {b_ext, 1'b0};
              cnt   <= CW'(N - 1);
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
